// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game round controller.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    GO,
    RESULT,
    FOUL
  } state_e;

  localparam int unsigned MS_W  = 14;
  localparam int unsigned DLY_W = 12;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and pulses tick_o on the last count.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned        CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // tick_o is not gated by clr_i: clr_i is derived from the FSM, which consumes tick_o
  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reaction_sequencer.sv
// Reaction-game round controller: random pre-GO delay, reaction timing in ms,
// false-start and timeout flagging; all outputs registered.
module reaction_sequencer
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned TIMEOUT_MS   = 9999,
  parameter int unsigned BLINK_MS     = 250
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            react,
  output logic            disp,
  output logic [MS_W-1:0] react_ms,
  output logic            result_valid,
  output logic            timeout,
  output logic            foul,
  output logic            busy
);

  localparam logic [DLY_W-1:0] MIN_DLY    = DLY_W'(MIN_DELAY_MS);
  localparam logic [MS_W-1:0]  TMO        = MS_W'(TIMEOUT_MS);
  localparam logic [MS_W-1:0]  BLINK_LAST = MS_W'(BLINK_MS - 1);

  state_e           state_q, state_d;
  logic             start_q, react_q;
  logic             start_rise, react_rise;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [DLY_W-1:0] delay_cnt_q, delay_cnt_d;
  logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d, ms_inc;
  logic [MS_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic             disp_q, disp_d;
  logic [MS_W-1:0]  react_ms_q, react_ms_d;
  logic             result_valid_q, result_valid_d;
  logic             timeout_q, timeout_d;
  logic             foul_q, foul_d;
  logic             busy_q, busy_d;
  logic             tick, tick_clr;

  assign start_rise = start & ~start_q;
  assign react_rise = react & ~react_q;
  assign ms_inc     = ms_cnt_q + MS_W'(1);
  assign tick_clr   = (state_d != state_q);

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_next(lfsr_q);
    delay_cnt_d    = delay_cnt_q;
    ms_cnt_d       = ms_cnt_q;
    blink_cnt_d    = blink_cnt_q;
    disp_d         = disp_q;
    react_ms_d     = react_ms_q;
    result_valid_d = result_valid_q;
    timeout_d      = timeout_q;
    foul_d         = foul_q;

    unique case (state_q)
      IDLE: begin
        if (start_rise) state_d = DELAY;
      end
      DELAY: begin
        // a press on the expiry tick still counts as a false start
        if (react_rise) begin
          state_d = FOUL;
        end else if (tick) begin
          if (delay_cnt_q == DLY_W'(1)) state_d = GO;
          else delay_cnt_d = delay_cnt_q - DLY_W'(1);
        end
      end
      GO: begin
        if (react_rise) begin
          state_d    = RESULT;
          react_ms_d = ms_cnt_q;
        end else if (tick) begin
          ms_cnt_d = ms_inc;
          if (ms_inc == TMO) begin
            state_d    = RESULT;
            react_ms_d = TMO;
            timeout_d  = 1'b1;
          end
        end
      end
      RESULT: begin
        if (start_rise) state_d = DELAY;
      end
      FOUL: begin
        if (start_rise) begin
          state_d = DELAY;
        end else if (tick) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            disp_d      = ~disp_q;
          end else begin
            blink_cnt_d = blink_cnt_q + MS_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      unique case (state_d)
        DELAY: begin
          delay_cnt_d    = MIN_DLY + DLY_W'(lfsr_q[10:0]);
          react_ms_d     = '0;
          result_valid_d = 1'b0;
          timeout_d      = 1'b0;
          foul_d         = 1'b0;
        end
        GO:      ms_cnt_d = '0;
        RESULT:  result_valid_d = 1'b1;
        FOUL: begin
          foul_d      = 1'b1;
          blink_cnt_d = '0;
        end
        default: ;
      endcase
    end

    if (state_d != FOUL) begin
      disp_d = (state_d != GO);
    end else if (state_q != FOUL) begin
      disp_d = 1'b0;
    end

    busy_d = (state_d == DELAY) || (state_d == GO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      start_q        <= 1'b0;
      react_q        <= 1'b0;
      lfsr_q         <= LFSR_SEED;
      delay_cnt_q    <= '0;
      ms_cnt_q       <= '0;
      blink_cnt_q    <= '0;
      disp_q         <= 1'b1;
      react_ms_q     <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      foul_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start;
      react_q        <= react;
      lfsr_q         <= lfsr_d;
      delay_cnt_q    <= delay_cnt_d;
      ms_cnt_q       <= ms_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      disp_q         <= disp_d;
      react_ms_q     <= react_ms_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
      foul_q         <= foul_d;
      busy_q         <= busy_d;
    end
  end

  assign disp         = disp_q;
  assign react_ms     = react_ms_q;
  assign result_valid = result_valid_q;
  assign timeout      = timeout_q;
  assign foul         = foul_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_reaction_sequencer.sv
// Scenario bench for reaction_sequencer with a reference LFSR and expected-value queues.
module tb_reaction_sequencer;

  localparam int TDIV  = 4;
  localparam int MIND  = 2;
  localparam int TMO   = 20;
  localparam int BLINK = 2;
  localparam int GO_LIMIT = 9000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        react = 1'b0;
  logic        disp;
  logic [13:0] react_ms;
  logic        result_valid, timeout, foul, busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  int          delay_q[$];
  int          ms_q[$];
  int          entries = 0;
  logic        busy_prev = 1'b0;

  reaction_sequencer #(
    .TICK_DIV    (TDIV),
    .MIN_DELAY_MS(MIND),
    .TIMEOUT_MS  (TMO),
    .BLINK_MS    (BLINK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .react       (react),
    .disp        (disp),
    .react_ms    (react_ms),
    .result_valid(result_valid),
    .timeout     (timeout),
    .foul        (foul),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  always @(negedge clk) begin
    if (busy === 1'b1 && busy_prev !== 1'b1) entries++;
    busy_prev = busy;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives a start edge; returns at the first negedge after DELAY entry (cycle 0).
  task automatic start_round(input bit hold);
    int d;
    @(negedge clk);
    d = MIND + int'(m_lfsr[10:0]);
    delay_q.push_back(d);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Waits for disp to fall, counting cycles from cycle 0, and checks the predicted delay.
  task automatic run_to_go(input string name);
    int cnt = 0;
    int exp;
    while (disp !== 1'b0 && cnt < GO_LIMIT) begin
      @(negedge clk);
      cnt++;
    end
    exp = delay_q.pop_front();
    checks++;
    if (cnt != 4 * exp) begin
      errors++;
      $display("FAIL %s_delay: got %0d cycles, expected %0d", name, cnt, 4 * exp);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_go_busy: got %0b, expected 1", name, busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; react = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (disp !== 1'b1) begin errors++; $display("FAIL reset_disp: got %0b, expected 1", disp); end
    checks++; if (react_ms !== 14'd0) begin errors++; $display("FAIL reset_react_ms: got %0d, expected 0", react_ms); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %0b, expected 0", result_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b, expected 0", timeout); end
    checks++; if (foul !== 1'b0) begin errors++; $display("FAIL reset_foul: got %0b, expected 0", foul); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
    checks++; if (dut.state_q !== reaction_pkg::IDLE) begin errors++; $display("FAIL reset_state: got %0d, expected IDLE", dut.state_q); end
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (disp !== 1'b1 || busy !== 1'b0 || foul !== 1'b0) begin
      errors++; $display("FAIL idle_react_ignored: got disp=%0b busy=%0b foul=%0b, expected 1/0/0", disp, busy, foul);
    end
  endtask

  task automatic test_normal_round;
    start_round(1'b0);
    checks++; if (busy !== 1'b1 || disp !== 1'b1) begin
      errors++; $display("FAIL normal_delay_entry: got busy=%0b disp=%0b, expected 1/1", busy, disp);
    end
    run_to_go("normal");
    repeat (28) @(negedge clk);
    react = 1'b1;
    ms_q.push_back(7);
    @(negedge clk);
    react = 1'b0;
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL normal_valid: got %0b, expected 1", result_valid); end
    checks++; if (react_ms !== 14'(ms_q.pop_front())) begin errors++; $display("FAIL normal_react_ms: got %0d, expected 7", react_ms); end
    checks++; if (disp !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL normal_result_flags: got disp=%0b busy=%0b timeout=%0b, expected 1/0/0", disp, busy, timeout);
    end
  endtask

  task automatic test_false_start;
    start_round(1'b0);
    repeat (2) @(negedge clk);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    checks++; if (foul !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL foul_entry: got foul=%0b busy=%0b, expected 1/0", foul, busy);
    end
    checks++; if (disp !== 1'b0) begin errors++; $display("FAIL foul_disp_k0: got %0b, expected 0", disp); end
    repeat (7) @(negedge clk);
    checks++; if (disp !== 1'b0) begin errors++; $display("FAIL foul_disp_k7: got %0b, expected 0", disp); end
    @(negedge clk);
    checks++; if (disp !== 1'b1) begin errors++; $display("FAIL foul_disp_k8: got %0b, expected 1", disp); end
    repeat (7) @(negedge clk);
    checks++; if (disp !== 1'b1) begin errors++; $display("FAIL foul_disp_k15: got %0b, expected 1", disp); end
    @(negedge clk);
    checks++; if (disp !== 1'b0) begin errors++; $display("FAIL foul_disp_k16: got %0b, expected 0", disp); end
    void'(delay_q.pop_front());
    start_round(1'b0);
    checks++; if (foul !== 1'b0 || busy !== 1'b1 || disp !== 1'b1) begin
      errors++; $display("FAIL foul_restart: got foul=%0b busy=%0b disp=%0b, expected 0/1/1", foul, busy, disp);
    end
  endtask

  task automatic test_timeout;
    run_to_go("timeout");
    ms_q.push_back(TMO);
    repeat (79) @(negedge clk);
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL timeout_early: got %0b, expected 0", result_valid); end
    @(negedge clk);
    checks++; if (result_valid !== 1'b1 || timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_flags: got valid=%0b timeout=%0b, expected 1/1", result_valid, timeout);
    end
    checks++; if (react_ms !== 14'(ms_q.pop_front())) begin errors++; $display("FAIL timeout_react_ms: got %0d, expected %0d", react_ms, TMO); end
  endtask

  task automatic test_coincident_timeout;
    start_round(1'b0);
    run_to_go("coincident");
    repeat (79) @(negedge clk);
    react = 1'b1;
    ms_q.push_back(TMO - 1);
    @(negedge clk);
    react = 1'b0;
    checks++; if (result_valid !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL coincident_flags: got valid=%0b timeout=%0b, expected 1/0", result_valid, timeout);
    end
    checks++; if (react_ms !== 14'(ms_q.pop_front())) begin errors++; $display("FAIL coincident_react_ms: got %0d, expected %0d", react_ms, TMO - 1); end
  endtask

  task automatic test_react_on_expiry;
    int d;
    start_round(1'b0);
    d = delay_q.pop_front();
    repeat (4 * d - 1) @(negedge clk);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    checks++; if (foul !== 1'b1 || busy !== 1'b0 || disp !== 1'b0) begin
      errors++; $display("FAIL expiry_foul: got foul=%0b busy=%0b disp=%0b, expected 1/0/0", foul, busy, disp);
    end
    checks++; if (react_ms !== 14'd0 || result_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL expiry_cleared: got ms=%0d valid=%0b timeout=%0b, expected 0/0/0", react_ms, result_valid, timeout);
    end
  endtask

  task automatic test_start_held;
    int base;
    base = entries;
    start_round(1'b1);
    run_to_go("held");
    repeat (12) @(negedge clk);
    react = 1'b1;
    ms_q.push_back(3);
    @(negedge clk);
    react = 1'b0;
    checks++; if (react_ms !== 14'(ms_q.pop_front())) begin errors++; $display("FAIL held_react_ms: got %0d, expected 3", react_ms); end
    repeat (10) @(negedge clk);
    checks++; if (result_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL held_stays_result: got valid=%0b busy=%0b, expected 1/0", result_valid, busy);
    end
    checks++; if (entries - base != 1) begin errors++; $display("FAIL held_entries: got %0d, expected 1", entries - base); end
    start = 1'b0;
  endtask

  task automatic test_rst_mid_go;
    start_round(1'b0);
    run_to_go("rst");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (disp !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_go_outputs: got disp=%0b busy=%0b, expected 1/0", disp, busy);
    end
    checks++; if (dut.state_q !== reaction_pkg::IDLE) begin errors++; $display("FAIL rst_go_state: got %0d, expected IDLE", dut.state_q); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || react_ms !== 14'd0) begin
      errors++; $display("FAIL rst_go_idle: got busy=%0b valid=%0b ms=%0d, expected 0/0/0", busy, result_valid, react_ms);
    end
  endtask

  initial begin
    test_reset;
    test_normal_round;
    test_false_start;
    test_timeout;
    test_coincident_timeout;
    test_react_on_expiry;
    test_start_held;
    test_rst_mid_go;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reaction_sequencer.md
# reaction_sequencer

Round controller for the reaction-time game: waits a pseudo-random delay after a start press, then drives the LED bank lit via `disp`, and measures the player's response in milliseconds. It sits between the debounced/synchronised push-buttons and the existing LED driver, which it sequences through `disp`. It also flags false starts and timeouts for the score display.

## Interface
- `TICK_DIV`, 50000 — clk cycles per millisecond tick (50 MHz board clock)
- `MIN_DELAY_MS`, 1000 — fixed part of the pre-GO delay; must be ≤ 2048
- `TIMEOUT_MS`, 9999 — GO-phase limit; must be ≤ 16383
- `BLINK_MS`, 250 — `disp` toggle period in FOUL
- `clk` in 1 — single clock, all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `start` in 1 — start button, already synchronised and debounced, level
- `react` in 1 — reaction button, already synchronised and debounced, level
- `disp` out 1 — to the LED driver: 1 = all LEDs dark, 0 = all lit
- `react_ms` out 14 — measured reaction time, valid while `result_valid`
- `result_valid` out 1 — round finished normally or by timeout
- `timeout` out 1 — round ended at `TIMEOUT_MS` without a press
- `foul` out 1 — `react` pressed before GO
- `busy` out 1 — high in DELAY and GO

## Operation
- Rising-edge detect on `start` and `react` internally (one registered copy each); only edges act, held levels do not.
- 16-bit Fibonacci LFSR, seed 16'hACE1, taps 16,14,13,11, free-running every cycle from reset; never all-zero.
- ms tick: prescaler counting 0..TICK_DIV-1, tick on TICK_DIV-1; cleared on every state entry.
- States:
  - IDLE (reset state): `disp`=1. `start` edge → DELAY.
  - DELAY: on entry load 12-bit `delay_cnt` = MIN_DELAY_MS + lfsr[10:0]; clear `react_ms`, `result_valid`, `timeout`, `foul`. `disp`=1, `busy`=1. Decrement `delay_cnt` on tick; tick with `delay_cnt`==1 → GO. `react` edge → FOUL.
  - GO: `disp`=0, `busy`=1; 14-bit `ms_cnt` cleared on entry, +1 per tick. `react` edge → RESULT, `react_ms` = `ms_cnt`. Tick that makes `ms_cnt` == TIMEOUT_MS → RESULT, `react_ms` = TIMEOUT_MS, `timeout`=1.
  - RESULT: `disp`=1, `result_valid`=1 held. `start` edge → DELAY.
  - FOUL: `foul`=1 held; `disp` starts at 0 and toggles every BLINK_MS ticks. `start` edge → DELAY.
- `start` edges in DELAY or GO are ignored; `react` edges in IDLE, RESULT and FOUL are ignored.
- Simultaneous events: `react` edge with DELAY expiry tick → FOUL; `react` edge with timeout tick → normal RESULT, `timeout`=0, `react_ms` = `ms_cnt` before increment.
- `rst` in any state → IDLE next edge, all counters cleared, LFSR reseeded.

## Timing
- Reset values: `disp`=1, `react_ms`=0, `result_valid`=0, `timeout`=0, `foul`=0, `busy`=0.
- All outputs registered; an input edge sampled at cycle n changes state and outputs at edge n+1.
- First tick in any state occurs TICK_DIV cycles after entry. DELAY lasts exactly `delay_cnt`×TICK_DIV cycles with no press.
- `react_ms` = count of completed ticks between GO entry and the press; resolution 1 ms, truncated.
- `react_ms`, `timeout`, `foul` hold until the next DELAY entry.

## Structure
- Package `reaction_pkg`: state enum (IDLE, DELAY, GO, RESULT, FOUL), LFSR seed and tap constants, `MS_W`=14, `DLY_W`=12.
- Sub-module `ms_tick_gen`: prescaler with synchronous clear input and 1-cycle `tick` output, parameter TICK_DIV.
- FSM, LFSR, edge detectors and counters live in the top module.

## Test plan
Bench uses TICK_DIV=4, MIN_DELAY_MS=2, TIMEOUT_MS=20, BLINK_MS=2.
- Reset: hold `rst` 3 cycles → all outputs at reset values, state IDLE; `react` pulse → no change.
- Normal round: `start` edge, model LFSR to predict delay D → `disp` falls exactly D×4 cycles after DELAY entry. Press `react` after 7 ticks → `result_valid`=1, `react_ms`=7, `disp`=1.
- False start: `react` edge 3 cycles into DELAY → `foul`=1, `disp` toggles every 8 cycles. Next `start` → `foul` clears, DELAY restarts.
- Timeout: no press in GO → after 80 cycles `result_valid`=1, `timeout`=1, `react_ms`=20. Coincident press on the 20th tick → `timeout`=0, `react_ms`=19.
- Boundaries: `react` edge on the DELAY expiry cycle → FOUL. `start` held high through a whole round → only one DELAY entry. `rst` asserted mid-GO → IDLE, `disp`=1, `busy`=0 next cycle.
